// File: rtl/stage_pipe_hs_pkg.sv
// Shared definitions for the stage_pipe_hs handshake pipeline: the occupancy
// width helper and the per-stage control decode.
package stage_pipe_hs_pkg;

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // clear outranks hold, so a simultaneous request collapses to CTL_CLEAR
   typedef enum logic [1:0] {
      CTL_RUN   = 2'd0,
      CTL_HOLD  = 2'd1,
      CTL_CLEAR = 2'd2
   } ctl_e;

endpackage

// File: rtl/stage_pipe_cell.sv
// One register stage of stage_pipe_hs: a {valid, data} record with load,
// flush and stall gating.
module stage_pipe_cell
   import stage_pipe_hs_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             nreset,
   input  ctl_e             ctl,
   input  logic             ready,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t st;
   logic   load;

   assign load = ready & (ctl == CTL_RUN);

   // data only moves with a real payload, so bubbles leave the old word in place
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         st <= '0;
      end else if (ctl == CTL_CLEAR) begin
         st <= '0;
      end else if (load) begin
         st.valid <= up_valid;
         if (up_valid) st.data <= up_data;
      end
   end

   assign valid = st.valid;
   assign data  = st.data;

endmodule

// File: rtl/stage_pipe_hs.sv
// DEPTH-stage valid/ready pipeline with bubble collapse, flush and stall.
// Define STAGE_PIPE_HS_OCC_EN to add the registered occupancy output.
module stage_pipe_hs
   import stage_pipe_hs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     clear,
   input  logic                     hold,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data
`ifdef STAGE_PIPE_HS_OCC_EN
   ,
   output logic [occ_w(DEPTH)-1:0]  occupancy
`endif
);

   ctl_e                        ctl;
   logic [DEPTH:0]              rdy;
   // index 0 is the producer side; index i+1 is the output of stage i
   logic [DEPTH:0]              src_v;
   logic [DEPTH:0][WIDTH-1:0]   src_d;

   assign ctl = clear ? CTL_CLEAR : (hold ? CTL_HOLD : CTL_RUN);

   assign src_v[0] = in_valid;
   assign src_d[0] = in_data;

   // a stage can take a word if it is empty or its own word moves on this edge
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy[i] = !src_v[i+1] | rdy[i+1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      stage_pipe_cell #(.WIDTH(WIDTH)) u_cell (
         .clk      (clk),
         .nreset   (nreset),
         .ctl      (ctl),
         .ready    (rdy[g]),
         .up_valid (src_v[g]),
         .up_data  (src_d[g]),
         .valid    (src_v[g+1]),
         .data     (src_d[g+1])
      );
   end

   assign in_ready  = rdy[0] & (ctl == CTL_RUN);
   assign out_valid = src_v[DEPTH] & (ctl == CTL_RUN);
   assign out_data  = src_d[DEPTH];

`ifdef STAGE_PIPE_HS_OCC_EN
   localparam int OCC_W = occ_w(DEPTH);

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // bubble moves never change the count; only end transfers do
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         occupancy <= '0;
      end else if (clear) begin
         occupancy <= '0;
      end else begin
         case ({in_fire, out_fire})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_stage_pipe_hs.sv
// Scoreboard bench for stage_pipe_hs (DEPTH=3, WIDTH=8): directed stimulus
// pushes accepted payloads, a negedge monitor pops and compares outputs.
module tb_stage_pipe_hs;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic             clk = 1'b0;
   logic             nreset;
   logic             clear;
   logic             hold;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef STAGE_PIPE_HS_OCC_EN
   logic [1:0]       occupancy;
`endif

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               idx;

   stage_pipe_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .clear     (clear),
      .hold      (hold),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef STAGE_PIPE_HS_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // any output with an empty queue is a stale, duplicated or invented payload
   always @(negedge clk) begin
      if (nreset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: got %0h expected no output at %0t", out_data, $time);
         end else begin
            chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [WIDTH-1:0] dat, input logic acc);
      in_valid = 1'b1;
      in_data  = dat;
      @(negedge clk);
      chk("in_ready", {31'h0, in_ready}, {31'h0, acc});
      if (in_ready) exp_q.push_back(dat);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      nreset = 1'b0; clear = 1'b0; hold = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_out_data", {24'h0, out_data}, 0);
`ifdef STAGE_PIPE_HS_OCC_EN
      chk("rst_occ", {30'h0, occupancy}, 0);
`endif
      #10 nreset = 1'b1;
      step();

      // fill with consumer stalled, then full-but-draining still accepts
      offer(8'h11, 1'b1);
      offer(8'h22, 1'b1);
      offer(8'h33, 1'b1);
      offer(8'h44, 1'b0);
      chk("full_out_valid", {31'h0, out_valid}, 1);
      chk("full_out_data", {24'h0, out_data}, 32'h11);
      out_ready = 1'b1;
      offer(8'h44, 1'b1);
      drain();
      chk("empty_after_drain", {31'h0, out_valid}, 0);

      // streaming: first output three cycles after first accept, then one per cycle
      out_ready = 1'b1;
      for (int k = 0; k < 19; k++) begin
         if (k < 16) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + k);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (k < 16) begin
            chk("stream_in_ready", {31'h0, in_ready}, 1);
            if (in_ready) exp_q.push_back(in_data);
         end
         chk("stream_out_valid", {31'h0, out_valid}, {31'h0, (k >= 3)});
         step();
      end
      in_valid = 1'b0;
      chk("stream_left", exp_q.size(), 0);

      // bubble collapse: two payloads never make the chain look full
      out_ready = 1'b0;
      offer(8'hA1, 1'b1);
      @(negedge clk);
      chk("gap_in_ready", {31'h0, in_ready}, 1);
      step();
      offer(8'hA2, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("collapse_in_ready", {31'h0, in_ready}, 1);
         step();
      end
      chk("collapse_out_data", {24'h0, out_data}, 32'hA1);
`ifdef STAGE_PIPE_HS_OCC_EN
      chk("collapse_occ", {30'h0, occupancy}, 2);
`endif

      // flush with input offered: everything dropped
      clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      @(negedge clk);
      chk("clr_in_ready", {31'h0, in_ready}, 0);
      chk("clr_out_valid", {31'h0, out_valid}, 0);
      step();
      clear = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("post_clr_out_valid", {31'h0, out_valid}, 0);
      chk("post_clr_out_data", {24'h0, out_data}, 0);
`ifdef STAGE_PIPE_HS_OCC_EN
      chk("post_clr_occ", {30'h0, occupancy}, 0);
`endif
      out_ready = 1'b1;
      repeat (5) step();

      // four-cycle stall in the middle of a stream
      out_ready = 1'b1;
      idx = 0;
      for (int k = 0; k < 25; k++) begin
         hold = (k >= 4 && k < 8);
         if (idx < 10) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + idx);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (hold) begin
            chk("hold_in_ready", {31'h0, in_ready}, 0);
            chk("hold_out_valid", {31'h0, out_valid}, 0);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            idx++;
         end
         step();
      end
      hold = 1'b0; in_valid = 1'b0;
      chk("hold_accepted", idx, 10);
      drain();

      // hold and clear together: the flush wins
      out_ready = 1'b0;
      offer(8'hB1, 1'b1);
      offer(8'hB2, 1'b1);
      hold = 1'b1; clear = 1'b1; in_valid = 1'b1; in_data = 8'hB3;
      @(negedge clk);
      chk("hc_in_ready", {31'h0, in_ready}, 0);
      chk("hc_out_valid", {31'h0, out_valid}, 0);
      step();
      hold = 1'b0; clear = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("hc_post_out_valid", {31'h0, out_valid}, 0);
      chk("hc_post_out_data", {24'h0, out_data}, 0);
`ifdef STAGE_PIPE_HS_OCC_EN
      chk("hc_post_occ", {30'h0, occupancy}, 0);
`endif
      out_ready = 1'b1;
      repeat (4) step();

      // asynchronous reset while full
      out_ready = 1'b0;
      offer(8'hC1, 1'b1);
      offer(8'hC2, 1'b1);
      offer(8'hC3, 1'b1);
      offer(8'hC4, 1'b0);
      chk("prerst_out_valid", {31'h0, out_valid}, 1);
      @(negedge clk);
      #2 nreset = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'h0, out_valid}, 0);
      chk("async_rst_out_data", {24'h0, out_data}, 0);
      exp_q.delete();
      @(posedge clk);
      #2 nreset = 1'b1;
`ifdef STAGE_PIPE_HS_OCC_EN
      chk("async_rst_occ", {30'h0, occupancy}, 0);
`endif
      offer(8'hD1, 1'b1);
      drain();

      chk("final_queue", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
